// File: rtl/bus_periph_ctrl.sv
// bus_periph_ctrl: registered bridge from the CPU bus to text area and PSRAM.
// Ports: clk_i/rstn_i, i_bus_* request, o_bus_* response, o_text_*/i_text_*
//        text-area side, o_psram_*/i_psram_* PSRAM controller side.
module bus_periph_ctrl #(
    parameter logic [7:0]  TEXT_BASE  = 8'h10,
    parameter logic [7:0]  PSRAM_BASE = 8'h40,
    parameter int          TIMEOUT    = 255,
    parameter int          TO_W       = 8,
    parameter logic [31:0] ERR_DATA   = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        i_bus_stb,
    input  logic        i_bus_we,
    input  logic [31:0] i_bus_addr,
    input  logic [31:0] i_bus_wr_data,
    output logic [31:0] o_bus_rd_data,
    output logic        o_bus_rd_ready,
    output logic        o_bus_err,
    output logic        o_bus_busy,
    output logic        o_text_cs,
    output logic        o_text_stb,
    output logic        o_text_we,
    output logic [6:0]  o_text_addr,
    output logic [7:0]  o_text_data,
    input  logic [7:0]  i_text_data,
    input  logic        i_text_ready,
    output logic        o_psram_cs,
    output logic        o_psram_stb,
    output logic        o_psram_we,
    output logic [23:0] o_psram_addr,
    output logic [15:0] o_psram_data,
    input  logic [15:0] i_psram_data,
    input  logic        i_psram_done,
    input  logic        i_psram_busy
);

    typedef enum logic [2:0] {
        IDLE, TEXT_ACC, PSRAM_WAIT, PSRAM_ACC, RESP
    } state_t;

    function automatic logic is_text(input logic [7:0] top);
        return top == TEXT_BASE;
    endfunction

    // PSRAM window is 8 MB: bit 23 must be clear
    function automatic logic is_psram(input logic [8:0] top9);
        return top9 == {PSRAM_BASE, 1'b0};
    endfunction

    state_t            state_q, state_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              err_q, err_d;
    logic              hold_q, hold_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              tstb_q, tstb_d;
    logic              pstb_q, pstb_d;
    logic              to_hit;
    logic              unused_wdata;

    // only the low 16 bits reach any peripheral
    assign unused_wdata = ^i_bus_wr_data[31:16];

    assign to_hit = (cnt_q == TO_W'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        hold_d  = 1'b0;
        rdata_d = rdata_q;
        tstb_d  = 1'b0;
        pstb_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_bus_stb) begin
                    we_d    = i_bus_we;
                    addr_d  = i_bus_addr;
                    wdata_d = i_bus_wr_data[15:0];
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    if (is_text(i_bus_addr[31:24])) begin
                        state_d = TEXT_ACC;
                        tstb_d  = 1'b1;
                    end else if (is_psram(i_bus_addr[31:23])) begin
                        state_d = PSRAM_WAIT;
                    end else begin
                        // extra RESP cycle gives unmapped accesses the
                        // same latency as a text write
                        state_d = RESP;
                        err_d   = 1'b1;
                        hold_d  = 1'b1;
                        rdata_d = ERR_DATA;
                    end
                end
            end
            TEXT_ACC: begin
                if (we_q) begin
                    state_d = RESP;
                    rdata_d = '0;
                end else if (i_text_ready) begin
                    state_d = RESP;
                    rdata_d = {24'b0, i_text_data};
                end else if (to_hit) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    rdata_d = ERR_DATA;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            PSRAM_WAIT: begin
                if (to_hit) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    rdata_d = ERR_DATA;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                    if (!i_psram_busy) begin
                        state_d = PSRAM_ACC;
                        pstb_d  = 1'b1;
                    end
                end
            end
            PSRAM_ACC: begin
                // completion beats a timeout landing on the same cycle
                if (i_psram_done) begin
                    state_d = RESP;
                    rdata_d = we_q ? 32'b0 : {16'b0, i_psram_data};
                end else if (to_hit) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    rdata_d = ERR_DATA;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            RESP: begin
                if (!hold_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            hold_q  <= 1'b0;
            rdata_q <= '0;
            tstb_q  <= 1'b0;
            pstb_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
            rdata_q <= rdata_d;
            tstb_q  <= tstb_d;
            pstb_q  <= pstb_d;
        end
    end

    assign o_bus_busy     = (state_q != IDLE);
    assign o_bus_rd_ready = (state_q == RESP) && !hold_q;
    assign o_bus_err      = o_bus_rd_ready && err_q;
    assign o_bus_rd_data  = rdata_q;

    assign o_text_cs   = o_bus_busy && is_text(addr_q[31:24]);
    assign o_text_stb  = tstb_q;
    assign o_text_we   = o_text_cs && we_q;
    assign o_text_addr = addr_q[6:0];
    assign o_text_data = wdata_q[7:0];

    assign o_psram_cs   = o_bus_busy && is_psram(addr_q[31:23]);
    assign o_psram_stb  = pstb_q;
    assign o_psram_we   = o_psram_cs && we_q;
    assign o_psram_addr = addr_q[23:0];
    assign o_psram_data = wdata_q;

endmodule

// File: tb/tb_bus_periph_ctrl.sv
// tb_bus_periph_ctrl: scoreboard bench for bus_periph_ctrl.
// Stimulus queues expected strobes/responses; monitors pop and compare.
module tb_bus_periph_ctrl;

    localparam logic [31:0] ERRD = 32'hDEAD_0BAD;
    localparam int          TMO  = 255;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        i_bus_stb = 1'b0;
    logic        i_bus_we = 1'b0;
    logic [31:0] i_bus_addr = '0;
    logic [31:0] i_bus_wr_data = '0;
    logic [31:0] o_bus_rd_data;
    logic        o_bus_rd_ready;
    logic        o_bus_err;
    logic        o_bus_busy;
    logic        o_text_cs;
    logic        o_text_stb;
    logic        o_text_we;
    logic [6:0]  o_text_addr;
    logic [7:0]  o_text_data;
    logic [7:0]  i_text_data = '0;
    logic        i_text_ready = 1'b0;
    logic        o_psram_cs;
    logic        o_psram_stb;
    logic        o_psram_we;
    logic [23:0] o_psram_addr;
    logic [15:0] o_psram_data;
    logic [15:0] i_psram_data = '0;
    logic        i_psram_done = 1'b0;
    logic        i_psram_busy = 1'b0;

    bus_periph_ctrl #(
        .TEXT_BASE (8'h10),
        .PSRAM_BASE(8'h40),
        .TIMEOUT   (TMO),
        .TO_W      (8),
        .ERR_DATA  (ERRD)
    ) dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .i_bus_stb     (i_bus_stb),
        .i_bus_we      (i_bus_we),
        .i_bus_addr    (i_bus_addr),
        .i_bus_wr_data (i_bus_wr_data),
        .o_bus_rd_data (o_bus_rd_data),
        .o_bus_rd_ready(o_bus_rd_ready),
        .o_bus_err     (o_bus_err),
        .o_bus_busy    (o_bus_busy),
        .o_text_cs     (o_text_cs),
        .o_text_stb    (o_text_stb),
        .o_text_we     (o_text_we),
        .o_text_addr   (o_text_addr),
        .o_text_data   (o_text_data),
        .i_text_data   (i_text_data),
        .i_text_ready  (i_text_ready),
        .o_psram_cs    (o_psram_cs),
        .o_psram_stb   (o_psram_stb),
        .o_psram_we    (o_psram_we),
        .o_psram_addr  (o_psram_addr),
        .o_psram_data  (o_psram_data),
        .i_psram_data  (i_psram_data),
        .i_psram_done  (i_psram_done),
        .i_psram_busy  (i_psram_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    typedef struct {
        int          at;
        logic        psram;
        logic        we;
        logic [23:0] addr;
        logic [15:0] data;
    } stb_t;

    rsp_t rq[$];
    stb_t sq[$];
    int   checks = 0;
    int   errors = 0;
    logic chk_idle = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // response monitor
    always @(negedge clk) begin
        rsp_t r;
        if (chk_idle) begin
            chk("busy_after_rsp", 64'(o_bus_busy), 64'd0);
            chk_idle = 1'b0;
        end
        if (rstn && o_bus_rd_ready) begin
            if (rq.size() == 0) begin
                chk("unexpected_ready", 64'd1, 64'd0);
            end else begin
                r = rq.pop_front();
                chk("rsp_cycle", 64'(cyc), 64'(r.at));
                chk("rsp_data", 64'(o_bus_rd_data), 64'(r.data));
                chk("rsp_err", 64'(o_bus_err), 64'(r.err));
            end
            chk_idle = 1'b1;
        end else if (rstn && o_bus_err) begin
            chk("err_without_ready", 64'd1, 64'd0);
        end
    end

    // peripheral strobe monitor
    always @(negedge clk) begin
        stb_t s;
        if (rstn && (o_text_stb || o_psram_stb)) begin
            if (sq.size() == 0) begin
                chk("unexpected_strobe", 64'd1, 64'd0);
            end else begin
                s = sq.pop_front();
                chk("stb_cycle", 64'(cyc), 64'(s.at));
                chk("stb_target", 64'(o_psram_stb), 64'(s.psram));
                if (o_text_stb) begin
                    chk("text_cs", 64'(o_text_cs), 64'd1);
                    chk("text_we", 64'(o_text_we), 64'(s.we));
                    chk("text_addr", 64'(o_text_addr), 64'(s.addr[6:0]));
                    chk("text_data", 64'(o_text_data), 64'(s.data[7:0]));
                end else begin
                    chk("psram_cs", 64'(o_psram_cs), 64'd1);
                    chk("psram_we", 64'(o_psram_we), 64'(s.we));
                    chk("psram_addr", 64'(o_psram_addr), 64'(s.addr));
                    chk("psram_data", 64'(o_psram_data), 64'(s.data));
                end
            end
        end
    end

    task automatic chk_all_zero(input string nm);
        chk({nm, "_rd_data"}, 64'(o_bus_rd_data), 64'd0);
        chk({nm, "_ctrl"},
            {o_bus_rd_ready, o_bus_err, o_bus_busy,
             o_text_cs, o_text_stb, o_text_we, o_text_addr, o_text_data,
             o_psram_cs, o_psram_stb, o_psram_we, o_psram_addr,
             o_psram_data}, 64'd0);
    endtask

    // One CPU access starting at the current negedge.
    // dly: edge index (1 = first edge after the strobe edge) at which the
    // completion is sampled; 0 = never. busy_n: edges PSRAM reports busy.
    // ign: edge index with a stray CPU strobe (0 = none).
    task automatic access(input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [15:0] rdat,
                          input int busy_n, input int dly, input int ign,
                          input logic late);
        int   c;
        int   k;
        rsp_t r;
        stb_t s;
        logic tx;
        logic ps;
        tx = (addr[31:24] == 8'h10);
        ps = (addr[31:24] == 8'h40) && !addr[23];
        c  = cyc;
        if (!tx && !ps) begin
            k = 1;
            r.data = ERRD;
            r.err  = 1'b1;
        end else if (tx && we) begin
            k = 1;
            r.data = 32'd0;
            r.err  = 1'b0;
        end else if (dly != 0 && dly <= TMO) begin
            k = dly;
            r.err = 1'b0;
            if (tx) r.data = {24'd0, rdat[7:0]};
            else if (we) r.data = 32'd0;
            else r.data = {16'd0, rdat};
        end else begin
            k = TMO;
            r.data = ERRD;
            r.err  = 1'b1;
        end
        r.at = c + 1 + k;
        rq.push_back(r);
        if (tx || ps) begin
            s.at    = tx ? c + 1 : c + busy_n + 2;
            s.psram = ps;
            s.we    = we;
            s.addr  = addr[23:0];
            s.data  = wd[15:0];
            sq.push_back(s);
        end
        i_bus_stb     = 1'b1;
        i_bus_we      = we;
        i_bus_addr    = addr;
        i_bus_wr_data = wd;
        for (int e = 1; e <= k + 1; e++) begin
            @(negedge clk);
            i_bus_stb    = (e == ign);
            i_bus_addr   = (e == ign) ? 32'h1000_0001 : addr;
            i_psram_busy = ps && (e <= busy_n);
            i_text_ready = (tx && !we && e == dly) || (late && e == k + 1);
            i_psram_done = (ps && e == dly) || (late && e == k + 1);
            i_text_data  = (e == dly) ? rdat[7:0] : 8'($urandom);
            i_psram_data = (e == dly) ? rdat : 16'($urandom);
        end
        @(negedge clk);
        i_bus_stb    = 1'b0;
        i_text_ready = late;
        i_psram_done = late;
        if (late) begin
            @(negedge clk);
            i_text_ready = 1'b0;
            i_psram_done = 1'b0;
        end
    endtask

    task automatic reset_mid();
        stb_t s;
        s.at    = cyc + 2;
        s.psram = 1'b1;
        s.we    = 1'b0;
        s.addr  = 24'h00_1234;
        s.data  = 16'h5A5A;
        sq.push_back(s);
        i_bus_stb     = 1'b1;
        i_bus_we      = 1'b0;
        i_bus_addr    = 32'h4000_1234;
        i_bus_wr_data = 32'h0000_5A5A;
        @(negedge clk);
        i_bus_stb = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk_all_zero("reset_mid");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] w;
        int          kind;
        int          b;
        int          d;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rstn = 1'b1;
        @(negedge clk);
        chk_all_zero("idle");

        access(1'b1, 32'h1000_0005, 32'h0000_00A5, 16'h0, 0, 0, 0, 1'b0);
        access(1'b0, 32'h1000_0012, 32'h0, 16'h003C, 0, 3, 0, 1'b0);
        access(1'b0, 32'h4000_0100, 32'h0, 16'hBEEF, 5, 9, 0, 1'b0);
        access(1'b0, 32'h4000_0200, 32'h0, 16'h0, 0, 0, 0, 1'b1);
        access(1'b0, 32'h2000_0000, 32'h0, 16'h0, 0, 0, 0, 1'b0);
        access(1'b1, 32'h4080_0000, 32'h0, 16'h0, 0, 0, 0, 1'b0);
        access(1'b0, 32'h1000_0044, 32'h0, 16'h0077, 0, 6, 2, 1'b0);
        access(1'b1, 32'h4000_0300, 32'h1234_C0DE, 16'h0, 1, 4, 3, 1'b0);
        access(1'b0, 32'h4000_0400, 32'h0, 16'h0, 0, TMO, 0, 1'b0);
        reset_mid();
        access(1'b1, 32'h4000_0010, 32'h0000_FACE, 16'h0, 0, 3, 0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 4);
            w    = $urandom;
            b    = $urandom_range(0, 4);
            if (kind <= 1) begin
                a = {8'h10, 24'($urandom)};
                d = $urandom_range(1, 8);
            end else if (kind <= 3) begin
                a = {8'h40, 1'b0, 23'($urandom)};
                d = b + 2 + $urandom_range(0, 5);
            end else begin
                do a = $urandom;
                while (a[31:24] == 8'h10 ||
                       (a[31:24] == 8'h40 && !a[23]));
                d = 1;
            end
            if ($urandom_range(0, 29) == 0) d = 0;
            access(1'($urandom), a, w, 16'($urandom), b, d,
                   (d > 3) ? $urandom_range(0, 3) : 0,
                   1'($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("rsp_queue_empty", 64'(rq.size()), 64'd0);
        chk("stb_queue_empty", 64'(sq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
